// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-input round-robin arbiter and its request source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;
  localparam int NUM_REQ          = 2;
  localparam int DEF_CNT_W        = 3;
  localparam int DEF_STARVE_LIMIT = 4;

  // One bit per requester, shared by the arbiter and the request source.
  typedef logic [NUM_REQ-1:0] req_vec_t;
endpackage

// File: rtl/two_client_request_source_if.sv
// Bundle between client logic / arbiter and the two-client request source.
// Latency: n/a (wires only).
// Backpressure: enq_ready per client; enq offered while enq_ready is low is dropped.
// Ports (master = request source, slave = clients + arbiter side):
//   enq, grants                         : into the source
//   enq_ready, requests, served,
//   pending0, pending1, starve, err     : out of the source
interface two_client_request_source_if
  import arb_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();
  req_vec_t           enq;
  req_vec_t           enq_ready;
  req_vec_t           requests;
  req_vec_t           grants;
  req_vec_t           served;
  logic [CNT_W-1:0]   pending0;
  logic [CNT_W-1:0]   pending1;
  req_vec_t           starve;
  logic               err;

  modport master (
    input  enq, grants,
    output enq_ready, requests, served, pending0, pending1, starve, err
  );

  modport slave (
    output enq, grants,
    input  enq_ready, requests, served, pending0, pending1, starve, err
  );
endinterface

// File: rtl/req_client_slot.sv
// One client of the request source: pending-job counter, wait counter, starve flag, served pulse.
// Latency: enq -> request 1 cycle; grant accept -> served 1 cycle; request is register-driven.
// Backpressure: enq_ready_o low when the counter is full; enq_i is then ignored.
// Ports: clk_i/rst_i (sync active-high), enq_i, grant_i, grant_both_i (both grants high),
//        enq_ready_o, request_o, served_o, pending_o, starve_o, viol_o (grant without request).
module req_client_slot
  import arb_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_i,
  input  logic             grant_i,
  input  logic             grant_both_i,
  output logic             enq_ready_o,
  output logic             request_o,
  output logic             served_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             starve_o,
  output logic             viol_o
);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       WAIT_MAX = 4'hF;
  localparam logic [3:0]       LIM_M1   = 4'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] pending_q, pending_d;
  logic [3:0]       wait_q, wait_d;
  logic             starve_q, starve_d;
  logic             served_q, served_d;
  logic             acc, enq_acc;

  assign request_o   = (pending_q != '0);
  assign enq_ready_o = (pending_q != CNT_MAX);
  assign pending_o   = pending_q;
  assign served_o    = served_q;
  assign starve_o    = starve_q;

  // A double grant is rejected for both clients, so it never consumes a job.
  assign acc     = grant_i & request_o & ~grant_both_i;
  assign enq_acc = enq_i & enq_ready_o;
  assign viol_o  = grant_i & ~request_o;

  always_comb begin
    pending_d = pending_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    served_d  = acc;

    // Full/empty guards live in enq_acc/acc, so neither direction can wrap.
    if (enq_acc && !acc) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (acc && !enq_acc) begin
      pending_d = pending_q - CNT_W'(1);
    end

    if (!request_o || acc) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 4'd1;
      // Flag on the edge that takes the wait count up to the limit.
      if (wait_q == LIM_M1) begin
        starve_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      wait_q    <= '0;
      starve_q  <= 1'b0;
      served_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      served_q  <= served_d;
    end
  end
endmodule

// File: rtl/two_client_request_source.sv
// Requester side of the two-input arbiter: queues jobs for two clients and checks the grants.
// Latency: enq -> requests 1 cycle; accepted grant -> served 1 cycle; err/starve 1 cycle.
// Backpressure: enq_ready[i] low while client i holds the maximum job count; enq is dropped.
// Ports: clk, rst (sync active-high), bus (master modport: enq, grants in;
//        enq_ready, requests, served, pending0/1, starve, err out).
module two_client_request_source
  import arb_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst,
  two_client_request_source_if.master bus
);
  logic     grant_both;
  req_vec_t viol;
  logic     err_q, err_d;

  assign grant_both = (bus.grants == 2'b11);

  req_client_slot #(.CNT_W(CNT_W), .STARVE_LIMIT(STARVE_LIMIT)) u_slot0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .enq_i        (bus.enq[0]),
    .grant_i      (bus.grants[0]),
    .grant_both_i (grant_both),
    .enq_ready_o  (bus.enq_ready[0]),
    .request_o    (bus.requests[0]),
    .served_o     (bus.served[0]),
    .pending_o    (bus.pending0),
    .starve_o     (bus.starve[0]),
    .viol_o       (viol[0])
  );

  req_client_slot #(.CNT_W(CNT_W), .STARVE_LIMIT(STARVE_LIMIT)) u_slot1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .enq_i        (bus.enq[1]),
    .grant_i      (bus.grants[1]),
    .grant_both_i (grant_both),
    .enq_ready_o  (bus.enq_ready[1]),
    .request_o    (bus.requests[1]),
    .served_o     (bus.served[1]),
    .pending_o    (bus.pending1),
    .starve_o     (bus.starve[1]),
    .viol_o       (viol[1])
  );

  assign err_d   = err_q | grant_both | (|viol);
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
endmodule

// File: doc/two_client_request_source.md
Name: two_client_request_source

Overview:
- Requester-side companion to the two-input round-robin arbiter. It queues jobs for two clients, drives `requests[1:0]` into the arbiter, and consumes `grants[1:0]` back from it.
- Tracks a pending-job count per client and emits a served pulse for each accepted grant.
- Monitors the grant stream for protocol violations and for starvation.
- Sits between client logic and the arbiter; also used as a bench-side driver/checker for the arbiter.

Parameters:
- CNT_W, default 3: width of each per-client pending counter; max pending = 2**CNT_W-1 (7).
- STARVE_LIMIT, default 4: consecutive cycles a client may request without a grant before it is flagged as starved; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- enq  in  2  bit i: add one job for client i this cycle.
- enq_ready  out  2  bit i: client i counter not full; combinational from the counter.
- requests  out  2  to arbiter; bit i = (pending_i != 0); combinational from registers only.
- grants  in  2  from arbiter; expected one-hot or zero.
- served  out  2  bit i pulses for 1 cycle, one cycle after client i's grant is accepted.
- pending0  out  CNT_W  pending count, client 0.
- pending1  out  CNT_W  pending count, client 1.
- starve  out  2  sticky; bit i set when client i's wait counter reaches STARVE_LIMIT.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - pending0 = pending1 = 0, so requests = 00 and enq_ready = 11.
  - served = 00, starve = 00, err = 0.
  - Wait counters = 0.
- Grant accept:
  - acc_i = grants[i] & requests[i] & (grants != 2'b11).
  - Evaluated against the current-cycle requests.
- Pending update per client, at posedge:
  - Accepted enq and acc_i together: no change.
  - Accepted enq only: +1.
  - acc_i only: -1.
  - Otherwise: hold.
- Enq acceptance:
  - enq[i] is accepted only when enq_ready[i] = 1.
  - When full, enq[i] is dropped silently, the counter saturates, and err is not set.
  - Consequence: enq on a full counter together with acc_i leaves the count at max-1 (the enq was not accepted).
- Latency:
  - An enq into an empty counter raises requests[i] in the next cycle.
  - Accepting the last job drops requests[i] in the next cycle.
  - served[i] is a registered copy of acc_i, so it appears exactly 1 cycle later.
- Wait counter i, 4-bit:
  - Cleared to 0 when requests[i] = 0 or acc_i = 1.
  - Otherwise increments, saturating at 15.
  - starve[i] is set, and held until rst, at the edge where the counter goes from STARVE_LIMIT-1 to STARVE_LIMIT.
- err is set, and held until rst, in either case:
  - grants == 2'b11.
  - grants[i] = 1 while requests[i] = 0.
- Erroneous grants never decrement any counter. A 2'b11 grant decrements neither counter.
- No state machine beyond the counters; each client path is independent apart from the shared err flag.
- Reset mid-operation clears all state in the following cycle, regardless of enq/grants in the reset cycle.
- Arithmetic: counters are unsigned CNT_W bits. Wrap-around is never allowed; increment and decrement are guarded by the full/empty conditions.

Decomposition:
- Shared package `arb_pkg`:
  - localparams NUM_REQ = 2, DEF_CNT_W = 3, DEF_STARVE_LIMIT = 4.
  - typedef `req_vec_t` = logic [NUM_REQ-1:0], used by both arbiter and source.
- One natural sub-module, `req_client_slot`, instanced twice:
  - Contains the pending counter, wait counter, starve flag and served register for one client.
  - Exports its per-client protocol-violation signal.
- The top level ORs the per-slot violation signals and adds the 2'b11 check to form err.

Test Plan:
- Reset then idle 5 cycles -> requests=00, enq_ready=11, pending0=pending1=0, served=00, err=0.
- enq=01 for 1 cycle; next cycle grants=01 -> requests=01 for exactly 1 cycle; served=01 one cycle after the grant; pending0 returns to 0; err=0.
- enq=11 3 times, then grant 01,10,01,10,01,10 against live requests -> served alternates 01,10,...; both pending counters reach 0; requests=00 afterwards.
- enq=01 for 9 cycles with no grants -> pending0 saturates at 7; enq_ready[0]=0 from the cycle after the 7th accept; err=0.
- requests=10 held with grants=00 for 4 cycles -> starve=10 after the 4th waiting cycle; a later grant clears the wait counter but starve stays 10.
- Either protocol violation -> err=1, no counter change:
  - grants=11 with requests=11;
  - or grants=01 with requests=10 (on a fresh reset).
  - Then rst=1 -> err=0 and all outputs at reset values the next cycle.
